// File: rtl/snake_pkg.sv
// Shared widths, colours and FSM encoding
// for the snake body tracker.
package snake_pkg;

  localparam int H_W     = 5;
  localparam int V_W     = 5;
  localparam int MAX_L   = 64;
  localparam int LEN_W   = 7;
  localparam int COLOR_W = 8;

  localparam logic [7:0] HEAD_CLR = 8'hff;
  localparam logic [7:0] BODY_CLR = 8'h0f;
  localparam logic [7:0] BG_CLR   = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PUSH,
    S_DRAW_HEAD,
    S_DRAW_BODY,
    S_ERASE_TAIL
  } state_t;

endpackage

// File: rtl/snake_seg_ram.sv
// Ring storage for body segments:
// one write port, registered read port.
module snake_seg_ram #(
  parameter int           W     = 10,
  parameter int           DEPTH = 64,
  parameter logic [W-1:0] INIT  = '0,
  localparam int          AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 0) ? INIT : '0;
      rdata <= '0;
    end else begin
      if (we)
        mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body ring buffer: self-bite scan,
// push/pop of segments and draw requests.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int H_LOGIC_WIDTH  = H_W,
  parameter int V_LOGIC_WIDTH  = V_W,
  parameter int MAX_LEN        = MAX_L,
  parameter int LEN_WIDTH      = LEN_W,
  parameter int COLOR_ID_WIDTH = COLOR_W,
  parameter logic [H_LOGIC_WIDTH-1:0]
    INIT_X = '0,
  parameter logic [V_LOGIC_WIDTH-1:0]
    INIT_Y = '0,
  parameter logic [COLOR_ID_WIDTH-1:0]
    HEAD_COLOR = COLOR_ID_WIDTH'(HEAD_CLR),
  parameter logic [COLOR_ID_WIDTH-1:0]
    BODY_COLOR = COLOR_ID_WIDTH'(BODY_CLR),
  parameter logic [COLOR_ID_WIDTH-1:0]
    BG_COLOR   = COLOR_ID_WIDTH'(BG_CLR)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step,
  input  logic [H_LOGIC_WIDTH-1:0]  head_x,
  input  logic [V_LOGIC_WIDTH-1:0]  head_y,
  input  logic                      grow,
  output logic                      busy,
  output logic                      done,
  output logic                      bite_self,
  output logic                      full,
  output logic [LEN_WIDTH-1:0]      length,
  output logic [H_LOGIC_WIDTH-1:0]  px,
  output logic [V_LOGIC_WIDTH-1:0]  py,
  output logic [COLOR_ID_WIDTH-1:0] pcolor,
  output logic                      pvld,
  input  logic                      pdone
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int SW = H_LOGIC_WIDTH + V_LOGIC_WIDTH;

  state_t          state, nstate;
  logic [PW-1:0]   wr_ptr, rd_ptr, raddr;
  logic [PW-1:0]   scan_base;
  logic [SW-1:0]   new_q, head_q, tail_q, rdata;
  logic [LEN_WIDTH-1:0] scan_idx, scan_cnt;
  logic            eff_grow_q, grow_now;
  logic            issued, done_q, bite_q;
  logic            is_draw, scan_last;
  logic            match, pdone_ok, len_one;

  assign len_one   = length == LEN_WIDTH'(1);
  assign full      = length == LEN_WIDTH'(MAX_LEN);
  assign grow_now  = grow && !full;
  assign scan_cnt  = eff_grow_q ? length
                   : length - LEN_WIDTH'(1);
  assign scan_last = scan_idx
                   == scan_cnt - LEN_WIDTH'(1);
  assign match     = rdata == new_q;
  assign pdone_ok  = issued && pdone;
  assign scan_base = eff_grow_q ? rd_ptr
                   : rd_ptr + PW'(1);
  assign is_draw   = state == S_DRAW_HEAD
                  || state == S_DRAW_BODY
                  || state == S_ERASE_TAIL;

  // Tail is skipped by the scan when it vacates;
  // the final read fetches it for the pop.
  always_comb begin
    raddr = rd_ptr;
    unique case (state)
      S_IDLE:
        if (!grow_now && !len_one)
          raddr = rd_ptr + PW'(1);
      S_SCAN:
        if (!scan_last)
          raddr = scan_base
                + PW'(scan_idx) + PW'(1);
      default: raddr = rd_ptr;
    endcase
  end

  snake_seg_ram #(
    .W     (SW),
    .DEPTH (MAX_LEN),
    .INIT  ({INIT_X, INIT_Y})
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (state == S_PUSH),
    .waddr (wr_ptr),
    .wdata (new_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:
        if (step)
          nstate = (len_one && !grow_now)
                 ? S_PUSH : S_SCAN;
      S_SCAN:
        if (match)
          nstate = S_IDLE;
        else if (scan_last)
          nstate = S_PUSH;
      S_PUSH:
        nstate = S_DRAW_HEAD;
      S_DRAW_HEAD:
        if (pdone_ok)
          nstate = (len_one && !eff_grow_q)
                 ? S_ERASE_TAIL : S_DRAW_BODY;
      S_DRAW_BODY:
        if (pdone_ok)
          nstate = eff_grow_q
                 ? S_IDLE : S_ERASE_TAIL;
      S_ERASE_TAIL:
        if (pdone_ok)
          nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= PW'(1);
      rd_ptr     <= '0;
      length     <= LEN_WIDTH'(1);
      new_q      <= '0;
      head_q     <= {INIT_X, INIT_Y};
      tail_q     <= '0;
      eff_grow_q <= 1'b0;
      scan_idx   <= '0;
      issued     <= 1'b0;
      done_q     <= 1'b0;
      bite_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bite_q <= 1'b0;
      issued <= is_draw && (nstate == state);
      unique case (state)
        S_IDLE:
          if (step) begin
            new_q      <= {head_x, head_y};
            eff_grow_q <= grow_now;
            scan_idx   <= '0;
          end
        S_SCAN: begin
          scan_idx <= scan_idx + LEN_WIDTH'(1);
          if (match)
            bite_q <= 1'b1;
        end
        S_PUSH: begin
          wr_ptr <= wr_ptr + PW'(1);
          tail_q <= rdata;
          if (eff_grow_q)
            length <= length + LEN_WIDTH'(1);
          else
            rd_ptr <= rd_ptr + PW'(1);
        end
        default:
          if (is_draw && nstate == S_IDLE) begin
            done_q <= 1'b1;
            head_q <= new_q;
          end
      endcase
    end
  end

  always_comb begin
    busy      = state != S_IDLE;
    done      = done_q;
    bite_self = bite_q;
    pvld      = is_draw && !issued;
    px        = '0;
    py        = '0;
    pcolor    = '0;
    unique case (1'b1)
      state == S_DRAW_HEAD: begin
        {px, py} = new_q;
        pcolor   = HEAD_COLOR;
      end
      state == S_DRAW_BODY: begin
        {px, py} = head_q;
        pcolor   = BODY_COLOR;
      end
      state == S_ERASE_TAIL: begin
        {px, py} = tail_q;
        pcolor   = BG_COLOR;
      end
      default: pcolor = '0;
    endcase
  end

endmodule
